// File: rtl/decoder_pipe.sv
// Registered RV32I (+Zicsr, optional RV32M) instruction decoder with a head/skid
// elastic buffer, so decode-to-execute sustains one instruction per cycle under back-pressure.
module decoder_pipe #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_CSR = 1'b1,
  parameter bit ENABLE_M   = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [31:0]      instr_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [1:0]       iadder_out_1_to_0_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  input  logic             flush_in,
  input  logic             trap_taken_in,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       rs1_out,
  output logic [4:0]       rs2_out,
  output logic [4:0]       rd_out,
  output logic [2:0]       wb_mux_sel_out,
  output logic [2:0]       imm_type_out,
  output logic [3:0]       alu_opcode_out,
  output logic [2:0]       csr_op_out,
  output logic [1:0]       load_size_out,
  output logic             load_unsigned_out,
  output logic             alu_src_out,
  output logic             iadder_src_out,
  output logic             rf_wr_en_out,
  output logic             csr_wr_en_out,
  output logic             muldiv_out,
  output logic             mem_wr_req_out,
  output logic             illegal_instr_out,
  output logic             misaligned_load_out,
  output logic             misaligned_store_out,
  output logic [CNT_W-1:0] illegal_cnt_out
);

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] wb_mux_sel;
    logic [2:0] imm_type;
    logic [3:0] alu_opcode;
    logic [2:0] csr_op;
    logic [1:0] load_size;
    logic       load_unsigned;
    logic       alu_src;
    logic       iadder_src;
    logic       rf_wr_en;
    logic       csr_wr_en;
    logic       muldiv;
    logic       mem_wr;
    logic       illegal;
    logic       mis_load;
    logic       mis_store;
  } bundle_t;

  function automatic bundle_t decode(input logic [31:0] ins, input logic [1:0] addr);
    bundle_t    d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_op_imm, is_op, is_fence, is_system, known, std_f7, m_f7;
    logic sys_csr, is_csr, is_md, ill, mis, shift_imm;
    d         = '0;
    op        = ins[6:0];
    f3        = ins[14:12];
    f7        = ins[31:25];
    is_lui    = (op == 7'b0110111);
    is_auipc  = (op == 7'b0010111);
    is_jal    = (op == 7'b1101111);
    is_jalr   = (op == 7'b1100111);
    is_branch = (op == 7'b1100011);
    is_load   = (op == 7'b0000011);
    is_store  = (op == 7'b0100011);
    is_op_imm = (op == 7'b0010011);
    is_op     = (op == 7'b0110011);
    is_fence  = (op == 7'b0001111);
    is_system = (op == 7'b1110011);
    known     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                is_op_imm | is_op | is_fence | is_system;
    std_f7    = (f7 == 7'b0000000) | (f7 == 7'b0100000);
    m_f7      = (f7 == 7'b0000001);
    sys_csr   = is_system & (f3 != 3'b000);
    is_csr    = sys_csr & ENABLE_CSR;
    is_md     = is_op & m_f7 & ENABLE_M;
    shift_imm = is_op_imm & (f3[1:0] == 2'b01);
    ill = (op[1:0] != 2'b11) | ~known | (sys_csr & ~ENABLE_CSR) |
          (is_op & ~(std_f7 | is_md)) |
          (is_op_imm & (f3 == 3'b001) & (f7 != 7'b0000000)) |
          (is_op_imm & (f3 == 3'b101) & ~std_f7);
    mis = ((f3 == 3'b010) & (addr != 2'b00)) | ((f3[1:0] == 2'b01) & addr[0]);

    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    if (is_load)                d.wb_mux_sel = 3'b001;
    else if (is_lui)            d.wb_mux_sel = 3'b010;
    else if (is_auipc)          d.wb_mux_sel = 3'b011;
    else if (is_csr)            d.wb_mux_sel = 3'b100;
    else if (is_jal | is_jalr)  d.wb_mux_sel = 3'b101;
    if (is_op_imm | is_load | is_jalr) d.imm_type = 3'b001;
    else if (is_store)                 d.imm_type = 3'b010;
    else if (is_branch)                d.imm_type = 3'b011;
    else if (is_lui | is_auipc)        d.imm_type = 3'b100;
    else if (is_jal)                   d.imm_type = 3'b101;
    else if (is_csr)                   d.imm_type = 3'b110;
    d.alu_opcode    = {f7[5] & (is_op | shift_imm), f3};
    d.csr_op        = is_csr ? f3 : 3'b000;
    d.load_size     = f3[1:0];
    d.load_unsigned = f3[2];
    d.alu_src       = op[5];
    d.iadder_src    = is_load | is_store | is_jalr;
    d.rf_wr_en      = ~ill & (is_lui | is_auipc | is_jal | is_jalr | is_op | is_op_imm |
                              is_load | (is_csr & (ins[11:7] != 5'd0)) | is_md);
    d.csr_wr_en     = ~ill & is_csr & ~(f3[1] & (ins[19:15] == 5'd0));
    d.muldiv        = ~ill & is_md;
    d.mem_wr        = ~ill & is_store;
    d.illegal       = ill;
    d.mis_load      = is_load & mis;
    d.mis_store     = is_store & mis;
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  bundle_t            dec_p0;
  bundle_t            head_p1, skid_p1;
  logic [XLEN-1:0]    pc_head_p1, pc_skid_p1;
  logic               vld_p1, vld_skid_p1;
  logic [CNT_W-1:0]   illegal_cnt;
  logic               acc, deq;

  assign dec_p0       = decode(instr_in, iadder_out_1_to_0_in);
  assign in_ready_out = ~vld_skid_p1;
  assign acc          = in_valid_in & ~vld_skid_p1 & ~flush_in;
  assign deq          = vld_p1 & out_ready_in & ~flush_in;

  // p0 -> p1: head/skid buffer control
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_p1      <= 1'b0;
      vld_skid_p1 <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (deq && head_p1.illegal) illegal_cnt <= sat_inc(illegal_cnt);
      if (flush_in) begin
        vld_p1      <= 1'b0;
        vld_skid_p1 <= 1'b0;
      end else if (!vld_p1) begin
        vld_p1 <= acc;
      end else if (deq) begin
        if (vld_skid_p1) vld_skid_p1 <= 1'b0;
        else             vld_p1      <= acc;
      end else if (acc) begin
        vld_skid_p1 <= 1'b1;
      end
    end
  end

  // p0 -> p1: bundle data, loaded only on the same transfers as the control above
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_p1    <= '0;
      skid_p1    <= '0;
      pc_head_p1 <= '0;
      pc_skid_p1 <= '0;
    end else if (!flush_in) begin
      if (!vld_p1 || (deq && !vld_skid_p1)) begin
        if (acc) begin
          head_p1    <= dec_p0;
          pc_head_p1 <= pc_in;
        end
      end else if (deq) begin
        head_p1    <= skid_p1;
        pc_head_p1 <= pc_skid_p1;
      end else if (acc) begin
        skid_p1    <= dec_p0;
        pc_skid_p1 <= pc_in;
      end
    end
  end

  assign out_valid_out        = vld_p1;
  assign pc_out               = pc_head_p1;
  assign rs1_out              = head_p1.rs1;
  assign rs2_out              = head_p1.rs2;
  assign rd_out               = head_p1.rd;
  assign wb_mux_sel_out       = head_p1.wb_mux_sel;
  assign imm_type_out         = head_p1.imm_type;
  assign alu_opcode_out       = head_p1.alu_opcode;
  assign csr_op_out           = head_p1.csr_op;
  assign load_size_out        = head_p1.load_size;
  assign load_unsigned_out    = head_p1.load_unsigned;
  assign alu_src_out          = head_p1.alu_src;
  assign iadder_src_out       = head_p1.iadder_src;
  assign rf_wr_en_out         = head_p1.rf_wr_en;
  assign csr_wr_en_out        = head_p1.csr_wr_en;
  assign muldiv_out           = head_p1.muldiv;
  assign illegal_instr_out    = head_p1.illegal;
  assign misaligned_load_out  = head_p1.mis_load;
  assign misaligned_store_out = head_p1.mis_store;
  assign illegal_cnt_out      = illegal_cnt;
  // Trap gating stays combinational so a same-cycle trap still blocks the store.
  assign mem_wr_req_out       = vld_p1 & head_p1.mem_wr & ~head_p1.mis_store & ~trap_taken_in;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: one instance with default options (CSR on, M off)
// and one alternate instance (CSR off, M on), both driven from the same stimulus.
module tb_decoder_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [1:0]  addr;
  logic        in_valid, out_ready, flush, trap;

  logic        in_ready, out_valid, rf_wr_en, csr_wr_en, muldiv, mem_wr_req;
  logic        ld_uns, alu_src, iadder_src, illegal, mis_ld, mis_st;
  logic [31:0] pc_o;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  wb_sel, imm_type, csr_op;
  logic [3:0]  alu_op;
  logic [1:0]  ld_size;
  logic [7:0]  cnt;

  logic        a_in_ready, a_out_valid, a_rf_wr_en, a_csr_wr_en, a_muldiv, a_mem_wr_req;
  logic        a_ld_uns, a_alu_src, a_iadder_src, a_illegal, a_mis_ld, a_mis_st;
  logic [31:0] a_pc_o;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_wb_sel, a_imm_type, a_csr_op;
  logic [3:0]  a_alu_op;
  logic [1:0]  a_ld_size;
  logic [7:0]  a_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_pipe #(.XLEN(32), .ENABLE_CSR(1'b1), .ENABLE_M(1'b0), .CNT_W(8)) dut (
    .clk_in(clk), .rst_in(rst), .instr_in(instr), .pc_in(pc),
    .iadder_out_1_to_0_in(addr), .in_valid_in(in_valid), .in_ready_out(in_ready),
    .out_valid_out(out_valid), .out_ready_in(out_ready), .flush_in(flush),
    .trap_taken_in(trap), .pc_out(pc_o), .rs1_out(rs1), .rs2_out(rs2), .rd_out(rd),
    .wb_mux_sel_out(wb_sel), .imm_type_out(imm_type), .alu_opcode_out(alu_op),
    .csr_op_out(csr_op), .load_size_out(ld_size), .load_unsigned_out(ld_uns),
    .alu_src_out(alu_src), .iadder_src_out(iadder_src), .rf_wr_en_out(rf_wr_en),
    .csr_wr_en_out(csr_wr_en), .muldiv_out(muldiv), .mem_wr_req_out(mem_wr_req),
    .illegal_instr_out(illegal), .misaligned_load_out(mis_ld),
    .misaligned_store_out(mis_st), .illegal_cnt_out(cnt)
  );

  decoder_pipe #(.XLEN(32), .ENABLE_CSR(1'b0), .ENABLE_M(1'b1), .CNT_W(8)) dut_alt (
    .clk_in(clk), .rst_in(rst), .instr_in(instr), .pc_in(pc),
    .iadder_out_1_to_0_in(addr), .in_valid_in(in_valid), .in_ready_out(a_in_ready),
    .out_valid_out(a_out_valid), .out_ready_in(out_ready), .flush_in(flush),
    .trap_taken_in(trap), .pc_out(a_pc_o), .rs1_out(a_rs1), .rs2_out(a_rs2), .rd_out(a_rd),
    .wb_mux_sel_out(a_wb_sel), .imm_type_out(a_imm_type), .alu_opcode_out(a_alu_op),
    .csr_op_out(a_csr_op), .load_size_out(a_ld_size), .load_unsigned_out(a_ld_uns),
    .alu_src_out(a_alu_src), .iadder_src_out(a_iadder_src), .rf_wr_en_out(a_rf_wr_en),
    .csr_wr_en_out(a_csr_wr_en), .muldiv_out(a_muldiv), .mem_wr_req_out(a_mem_wr_req),
    .illegal_instr_out(a_illegal), .misaligned_load_out(a_mis_ld),
    .misaligned_store_out(a_mis_st), .illegal_cnt_out(a_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = '0; pc = '0; addr = 2'b00;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; trap = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Fill both entries, then reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093; pc = 32'h100;
    tick();
    instr = 32'h0020A023; pc = 32'h104;
    tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_head_pc", pc_o, 32'h100);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_mem_wr", mem_wr_req, 0);
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00500093; pc = 32'h200;
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", rd, 1);
    chk("addi_imm", imm_type, 3'b001);
    chk("addi_alu", alu_op, 4'b0000);
    chk("addi_rf_wr", rf_wr_en, 1);
    chk("addi_pc", pc_o, 32'h200);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // Back-pressure: head held, second goes to skid, both drain in order
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
    tick();
    instr = 32'h0020A023;
    tick();
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    chk("bp_hold_rd", rd, 1);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_sw_valid", out_valid, 1);
    chk("bp_sw_imm", imm_type, 3'b010);
    chk("bp_sw_mem_wr", mem_wr_req, 1);
    chk("bp_sw_rs2", rs2, 2);
    chk("bp_in_ready_back", in_ready, 1);
    tick();
    chk("bp_empty", out_valid, 0);

    // Continuous valid/ready: one instruction per cycle
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      instr = 32'h00500013 | (k << 7);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_rd", rd, k);
      chk("stream_in_ready", in_ready, 1);
    end
    instr = 32'h4030D093;
    tick();
    chk("srai_alu", alu_op, 4'hD);
    chk("srai_illegal", illegal, 0);

    // Misaligned load / store, trap gating
    instr = 32'h0000A103; addr = 2'b10;
    tick();
    chk("lw_mis", mis_ld, 1);
    chk("lw_rf_wr", rf_wr_en, 1);
    chk("lw_wb", wb_sel, 3'b001);
    instr = 32'h0020A023; addr = 2'b01;
    tick();
    chk("sw_mis", mis_st, 1);
    chk("sw_mis_mem_wr", mem_wr_req, 0);
    addr = 2'b00;
    tick();
    in_valid = 1'b0;
    chk("sw_ok_mem_wr", mem_wr_req, 1);
    chk("sw_ok_mis", mis_st, 0);
    trap = 1'b1;
    #1;
    chk("sw_trap_mem_wr", mem_wr_req, 0);
    trap = 1'b0;
    tick();

    // CSR: enabled on main instance, illegal on alternate
    in_valid = 1'b1; instr = 32'h300110F3;
    tick();
    in_valid = 1'b0;
    chk("csr_wb", wb_sel, 3'b100);
    chk("csr_op", csr_op, 3'b001);
    chk("csr_wr", csr_wr_en, 1);
    chk("csr_imm", imm_type, 3'b110);
    chk("csr_illegal", illegal, 0);
    chk("csr_rf_wr", rf_wr_en, 1);
    chk("alt_csr_illegal", a_illegal, 1);
    chk("alt_csr_rf_wr", a_rf_wr_en, 0);
    tick();
    chk("alt_csr_cnt", a_cnt, 1);
    chk("csr_cnt", cnt, 0);

    // MUL: illegal on main instance, legal on alternate
    in_valid = 1'b1; instr = 32'h022081B3;
    tick();
    in_valid = 1'b0;
    chk("mul_illegal", illegal, 1);
    chk("mul_rf_wr", rf_wr_en, 0);
    chk("mul_muldiv", muldiv, 0);
    chk("alt_mul_muldiv", a_muldiv, 1);
    chk("alt_mul_illegal", a_illegal, 0);
    chk("alt_mul_rf_wr", a_rf_wr_en, 1);
    tick();
    chk("mul_cnt", cnt, 1);
    chk("alt_mul_cnt", a_cnt, 1);

    // Flush with both entries full, then with only the head full
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
    tick();
    instr = 32'h00500113;
    tick();
    flush = 1'b1; instr = 32'h00500293;
    tick();
    chk("flush_full_valid", out_valid, 0);
    chk("flush_full_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_full_gone", out_valid, 0);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
    tick();
    flush = 1'b1; out_ready = 1'b1; instr = 32'h00500293;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_head_valid", out_valid, 0);
    tick();
    chk("flush_head_gone", out_valid, 0);
    chk("flush_keeps_cnt", cnt, 1);

    // Saturating illegal counter
    rst = 1'b1;
    #1;
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00000000;
    for (int i = 0; i < 100; i++) tick();
    chk("zero_illegal", illegal, 1);
    chk("cnt_99", cnt, 99);
    for (int i = 0; i < 200; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("cnt_sat", cnt, 255);
    chk("alt_cnt_sat", a_cnt, 255);
    chk("sat_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
